// File: rtl/ra_pkg.sv
// Shared definitions for the ra_sdr_nr1w register array: slice width,
// clear-sequencer state encoding and parameter helper functions.
package ra_pkg;

  localparam int RA_SLICE_W = 24;

  typedef enum logic [1:0] {
    RST = 2'd0,
    CLR = 2'd1,
    RDY = 2'd2
  } ra_state_e;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

  function automatic bit ra_params_ok(input int depth, input int width,
                                      input int nrd, input int latchrd);
    return (depth >= 16) && (depth <= 256) && ((depth & (depth - 1)) == 0) &&
           (width >= RA_SLICE_W) && ((width % RA_SLICE_W) == 0) &&
           (nrd >= 1) && (nrd <= 4) && ((latchrd == 0) || (latchrd == 1));
  endfunction

endpackage

// File: rtl/ra_sdr_slice.sv
// One 24-bit wide storage slice: DEPTH entries, NRD asynchronous read ports
// and a single synchronous write port.
module ra_sdr_slice
  import ra_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int NRD   = 2,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic                        clk_i,
  input  logic                        we_i,
  input  logic [AW-1:0]               wa_i,
  input  logic [RA_SLICE_W-1:0]       wd_i,
  input  logic [NRD*AW-1:0]           ra_i,
  output logic [NRD*RA_SLICE_W-1:0]   rd_o
);

  logic [RA_SLICE_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wa_i] <= wd_i;
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    assign rd_o[p*RA_SLICE_W +: RA_SLICE_W] = mem_q[ra_i[p*AW +: AW]];
  end

endmodule

// File: rtl/ra_sdr_nr1w.sv
// DEPTH x WIDTH register array, NRD read ports and one write port, with a
// clear-on-reset sequencer. Define RA_BYPASS_EN for write-to-read forwarding.
module ra_sdr_nr1w
  import ra_pkg::*;
#(
  parameter int DEPTH    = 64,
  parameter int WIDTH    = 72,
  parameter int NRD      = 2,
  parameter int LATCHRD  = 1,
  parameter bit INIT_VAL = 1'b0,
  localparam int AW      = clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NRD-1:0]       rd_enb_i,
  input  logic [NRD*AW-1:0]    rd_adr_i,
  output logic [NRD*WIDTH-1:0] rd_dat_o,
  output logic [NRD-1:0]       rd_val_o,
  input  logic                 wr_enb_i,
  input  logic [AW-1:0]        wr_adr_i,
  input  logic [WIDTH-1:0]     wr_dat_i,
  output logic                 wr_rdy_o,
  output logic                 init_done_o
);

  localparam int NSL = WIDTH / RA_SLICE_W;

  if (!ra_params_ok(DEPTH, WIDTH, NRD, LATCHRD)) begin : g_param_err
    $error("ra_sdr_nr1w: illegal DEPTH/WIDTH/NRD/LATCHRD combination");
  end

  logic [NRD-1:0]            rd_enb_q;
  logic [NRD*AW-1:0]         rd_adr_q;
  logic                      wr_acc_q;
  logic [AW-1:0]             wr_adr_q;
  logic [WIDTH-1:0]          wr_dat_q;
  ra_state_e                 state_q;
  logic [AW-1:0]             cnt_q;
  logic                      wr_rdy_q;
  logic                      init_done_q;
  logic                      mem_we;
  logic [AW-1:0]             mem_wa;
  logic [WIDTH-1:0]          mem_wd;
  logic [NRD-1:0]            rd_en;
  logic [NRD-1:0][WIDTH-1:0] rd_raw;
  logic [NRD*RA_SLICE_W-1:0] sl_rd [NSL];

  // Requests offered while wr_rdy is low are dropped here, not retried.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_enb_q <= '0;
      rd_adr_q <= '0;
      wr_acc_q <= 1'b0;
      wr_adr_q <= '0;
      wr_dat_q <= '0;
    end else begin
      rd_enb_q <= rd_enb_i;
      rd_adr_q <= rd_adr_i;
      wr_acc_q <= wr_enb_i & wr_rdy_q;
      wr_adr_q <= wr_adr_i;
      wr_dat_q <= wr_dat_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RST;
      cnt_q       <= '0;
      wr_rdy_q    <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        RST: begin
          state_q <= CLR;
          cnt_q   <= '0;
        end
        CLR: begin
          if (cnt_q == AW'(DEPTH - 1)) begin
            state_q     <= RDY;
            wr_rdy_q    <= 1'b1;
            init_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RDY: state_q <= RDY;
        default: state_q <= RST;
      endcase
    end
  end

  always_comb begin
    mem_we = 1'b0;
    mem_wa = wr_adr_q;
    mem_wd = wr_dat_q;
    if (state_q == CLR) begin
      mem_we = 1'b1;
      mem_wa = cnt_q;
      mem_wd = {WIDTH{INIT_VAL}};
    end else if (wr_acc_q) begin
      mem_we = 1'b1;
    end
  end

  for (genvar s = 0; s < NSL; s++) begin : g_slice
    ra_sdr_slice #(
      .DEPTH (DEPTH),
      .NRD   (NRD)
    ) u_slice (
      .clk_i (clk_i),
      .we_i  (mem_we),
      .wa_i  (mem_wa),
      .wd_i  (mem_wd[s*RA_SLICE_W +: RA_SLICE_W]),
      .ra_i  (rd_adr_q),
      .rd_o  (sl_rd[s])
    );
  end

  assign rd_en = rd_enb_q & {NRD{state_q == RDY}};

  always_comb begin
    rd_raw = '0;
    for (int p = 0; p < NRD; p++) begin
      for (int s = 0; s < NSL; s++) begin
        rd_raw[p][s*RA_SLICE_W +: RA_SLICE_W] = sl_rd[s][p*RA_SLICE_W +: RA_SLICE_W];
      end
`ifdef RA_BYPASS_EN
      if (wr_acc_q && (rd_adr_q[p*AW +: AW] == wr_adr_q)) rd_raw[p] = wr_dat_q;
`endif
    end
  end

  if (LATCHRD != 0) begin : g_latch
    logic [NRD-1:0][WIDTH-1:0] rd_dat_q;
    logic [NRD-1:0]            rd_val_q;

    // Only valid reads update a port's latch, so idle ports keep their data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rd_dat_q <= '0;
        rd_val_q <= '0;
      end else begin
        rd_val_q <= rd_en;
        for (int p = 0; p < NRD; p++) begin
          if (rd_en[p]) rd_dat_q[p] <= rd_raw[p];
        end
      end
    end

    assign rd_dat_o = rd_dat_q;
    assign rd_val_o = rd_val_q;
  end else begin : g_nolatch
    assign rd_dat_o = rd_raw;
    assign rd_val_o = rd_en;
  end

  assign wr_rdy_o    = wr_rdy_q;
  assign init_done_o = init_done_q;

endmodule

// File: tb/tb_ra_sdr_nr1w.sv
// Scoreboard bench for ra_sdr_nr1w: a default 64x72 2-read latched array and
// a 128x48 4-read unlatched array with INIT_VAL=1 share clock and reset.
module tb_ra_sdr_nr1w;

  typedef struct packed {
    int          cyc;
    int          port;
    logic [71:0] data;
  } ev_t;

`ifdef RA_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [1:0]   rd_enb = '0;
  logic [11:0]  rd_adr = '0;
  logic [143:0] rd_dat;
  logic [1:0]   rd_val;
  logic         wr_enb = 1'b0;
  logic [5:0]   wr_adr = '0;
  logic [71:0]  wr_dat = '0;
  logic         wr_rdy, init_done;

  logic [3:0]   rd_enb4 = '0;
  logic [27:0]  rd_adr4 = '0;
  logic [191:0] rd_dat4;
  logic [3:0]   rd_val4;
  logic         wr_enb4 = 1'b0;
  logic [6:0]   wr_adr4 = '0;
  logic [47:0]  wr_dat4 = '0;
  logic         wr_rdy4, init_done4;

  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  ev_t  exp_q[$];
  ev_t  obs_q[$];
  ev_t  exp4_q[$];
  ev_t  obs4_q[$];
  logic [71:0] model [64];

  ra_sdr_nr1w u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rd_enb_i(rd_enb), .rd_adr_i(rd_adr), .rd_dat_o(rd_dat), .rd_val_o(rd_val),
    .wr_enb_i(wr_enb), .wr_adr_i(wr_adr), .wr_dat_i(wr_dat),
    .wr_rdy_o(wr_rdy), .init_done_o(init_done)
  );

  ra_sdr_nr1w #(.DEPTH(128), .WIDTH(48), .NRD(4), .LATCHRD(0), .INIT_VAL(1'b1)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n),
    .rd_enb_i(rd_enb4), .rd_adr_i(rd_adr4), .rd_dat_o(rd_dat4), .rd_val_o(rd_val4),
    .wr_enb_i(wr_enb4), .wr_adr_i(wr_adr4), .wr_dat_i(wr_dat4),
    .wr_rdy_o(wr_rdy4), .init_done_o(init_done4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ev_t ev;
    for (int p = 0; p < 2; p++) begin
      if (rd_val[p] === 1'b1) begin
        ev.cyc = cyc; ev.port = p; ev.data = rd_dat[p*72 +: 72];
        obs_q.push_back(ev);
      end
    end
    for (int p = 0; p < 4; p++) begin
      if (rd_val4[p] === 1'b1) begin
        ev.cyc = cyc; ev.port = p; ev.data = {24'b0, rd_dat4[p*48 +: 48]};
        obs4_q.push_back(ev);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic drive(input logic [1:0] ren, input logic [5:0] a0, input logic [5:0] a1,
                       input logic wen, input logic [5:0] wa, input logic [71:0] wd);
    rd_enb = ren; rd_adr = {a1, a0};
    wr_enb = wen; wr_adr = wa; wr_dat = wd;
    @(negedge clk);
    rd_enb = '0; wr_enb = 1'b0;
  endtask

  task automatic drive4(input logic [3:0] ren, input logic [27:0] radr,
                        input logic wen, input logic [6:0] wa, input logic [47:0] wd);
    rd_enb4 = ren; rd_adr4 = radr;
    wr_enb4 = wen; wr_adr4 = wa; wr_dat4 = wd;
    @(negedge clk);
    rd_enb4 = '0; wr_enb4 = 1'b0;
  endtask

  task automatic expect1(input int c, input int p, input logic [71:0] d);
    ev_t ev;
    ev.cyc = c; ev.port = p; ev.data = d;
    exp_q.push_back(ev);
  endtask

  task automatic expect4(input int c, input int p, input logic [47:0] d);
    ev_t ev;
    ev.cyc = c; ev.port = p; ev.data = {24'b0, d};
    exp4_q.push_back(ev);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (wr_rdy !== 1'b0) begin fails++; $display("FAIL reset_wr_rdy: got %b, expected 0", wr_rdy); end
    checks++;
    if (init_done !== 1'b0) begin fails++; $display("FAIL reset_init_done: got %b, expected 0", init_done); end
    checks++;
    if (rd_val !== 2'b00) begin fails++; $display("FAIL reset_rd_val: got %b, expected 00", rd_val); end
    checks++;
    if (rd_dat !== 144'h0) begin fails++; $display("FAIL reset_rd_dat: got %h, expected 0", rd_dat); end
    checks++;
    if (wr_rdy4 !== 1'b0 || init_done4 !== 1'b0) begin
      fails++; $display("FAIL reset_dut4_flags: got rdy=%b done=%b, expected 0 0", wr_rdy4, init_done4);
    end
    checks++;
    if (rd_val4 !== 4'b0000) begin fails++; $display("FAIL reset_dut4_rd_val: got %b, expected 0000", rd_val4); end
  endtask

  task automatic test_clear();
    int k, z1, z4, c;
    ev_t e, o;
    for (int i = 0; i < 64; i++) model[i] = '0;
    rst_n = 1'b1;
    k = cyc;
    z1 = 0; z4 = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!wr_rdy) z1++;
      if (!wr_rdy4) z4++;
      if (wr_rdy && wr_rdy4) break;
      wr_enb = (cyc - k == 10); wr_adr = 6'd7; wr_dat = '1;
      wr_enb4 = (cyc - k == 10); wr_adr4 = 7'd7; wr_dat4 = '0;
      rd_enb = (cyc - k == 5) ? 2'b11 : 2'b00; rd_adr = {6'd63, 6'd0};
      rd_enb4 = (cyc - k == 5) ? 4'hF : 4'h0;
    end
    rd_enb = '0; wr_enb = 1'b0; rd_enb4 = '0; wr_enb4 = 1'b0;
    checks++;
    if (z1 != 64) begin fails++; $display("FAIL clear_duration: got %0d cycles with wr_rdy=0, expected 64", z1); end
    checks++;
    if (z4 != 128) begin fails++; $display("FAIL clear_duration_dut4: got %0d cycles with wr_rdy=0, expected 128", z4); end
    checks++;
    if (init_done !== 1'b1 || init_done4 !== 1'b1) begin
      fails++; $display("FAIL clear_init_done: got %b/%b, expected 1/1", init_done, init_done4);
    end
    checks++;
    if (obs_q.size() != 0 || obs4_q.size() != 0) begin
      fails++; $display("FAIL clear_rd_val: got %0d/%0d valid reads during clear, expected 0/0", obs_q.size(), obs4_q.size());
    end
    obs_q.delete(); obs4_q.delete();
    c = cyc; expect1(c + 2, 0, model[0]); expect1(c + 2, 1, model[31]);
    drive(2'b11, 6'd0, 6'd31, 1'b0, 6'd0, '0);
    c = cyc; expect1(c + 2, 0, model[63]); expect1(c + 2, 1, model[7]);
    drive(2'b11, 6'd63, 6'd7, 1'b0, 6'd0, '0);
    for (int w = 0; w < 20 && obs_q.size() < exp_q.size(); w++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL clear_rd_count: got %0d read events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL clear_rd_data: got cyc=%0d port=%0d data=%h, expected cyc=%0d port=%0d data=%h",
                 o.cyc, o.port, o.data, e.cyc, e.port, e.data);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_write_read();
    int c;
    ev_t e, o;
    model[5] = {9{8'hA5}};
    drive(2'b00, 6'd0, 6'd0, 1'b1, 6'd5, {9{8'hA5}});
    c = cyc; expect1(c + 2, 0, model[0]); expect1(c + 2, 1, model[5]);
    drive(2'b11, 6'd0, 6'd5, 1'b0, 6'd0, '0);
    for (int w = 0; w < 20 && obs_q.size() < exp_q.size(); w++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL wr_rd_count: got %0d read events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL wr_rd_data: got cyc=%0d port=%0d data=%h, expected cyc=%0d port=%0d data=%h",
                 o.cyc, o.port, o.data, e.cyc, e.port, e.data);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_same_edge();
    int c;
    ev_t e, o;
    c = cyc; expect1(c + 2, 0, BYP ? 72'h1234 : model[9]);
    model[9] = 72'h1234;
    drive(2'b01, 6'd9, 6'd0, 1'b1, 6'd9, 72'h1234);
    c = cyc; expect1(c + 2, 1, model[9]);
    drive(2'b10, 6'd0, 6'd9, 1'b0, 6'd0, '0);
    for (int w = 0; w < 20 && obs_q.size() < exp_q.size(); w++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL same_edge_count: got %0d read events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL same_edge_data: got cyc=%0d port=%0d data=%h, expected cyc=%0d port=%0d data=%h",
                 o.cyc, o.port, o.data, e.cyc, e.port, e.data);
      end
    end
    exp_q.delete(); obs_q.delete();
    checks++;
    if (rd_val[1] !== 1'b0 || rd_dat[72 +: 72] !== 72'h1234) begin
      fails++; $display("FAIL latch_hold: got val=%b data=%h, expected val=0 data=1234", rd_val[1], rd_dat[72 +: 72]);
    end
  endtask

  task automatic test_back_to_back();
    int c, a0, a1, last_wa;
    logic [95:0] r;
    ev_t e, o;
    last_wa = 0;
    for (int i = 0; i < 8; i++) begin
      r = {$urandom(), $urandom(), $urandom()};
      last_wa = int'($urandom_range(0, 63));
      model[last_wa] = r[71:0];
      drive(2'b00, 6'd0, 6'd0, 1'b1, 6'(last_wa), r[71:0]);
    end
    for (int i = 0; i < 8; i++) begin
      a0 = (i == 0) ? last_wa : int'($urandom_range(0, 63));
      a1 = (i == 3) ? a0 : int'($urandom_range(0, 63));
      c = cyc; expect1(c + 2, 0, model[a0]); expect1(c + 2, 1, model[a1]);
      drive(2'b11, 6'(a0), 6'(a1), 1'b0, 6'd0, '0);
    end
    for (int w = 0; w < 20 && obs_q.size() < exp_q.size(); w++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL b2b_count: got %0d read events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL b2b_data: got cyc=%0d port=%0d data=%h, expected cyc=%0d port=%0d data=%h",
                 o.cyc, o.port, o.data, e.cyc, e.port, e.data);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_wide_ports();
    int c;
    logic [27:0] radr;
    ev_t e, o;
    for (int p = 0; p < 4; p++) drive4(4'h0, '0, 1'b1, 7'((p < 2) ? p : p + 124), 48'(p));
    radr = '0;
    for (int p = 0; p < 4; p++) radr[p*7 +: 7] = 7'((p < 2) ? p : p + 124);
    c = cyc;
    for (int p = 0; p < 4; p++) expect4(c + 1, p, 48'(p));
    drive4(4'hF, radr, 1'b0, '0, '0);
    c = cyc;
    for (int p = 0; p < 4; p++) expect4(c + 1, p, 48'd2);
    drive4(4'hF, {4{7'd126}}, 1'b0, '0, '0);
    c = cyc; expect4(c + 1, 2, '1); expect4(c + 1, 3, '1);
    drive4(4'b1100, {7'd7, 7'd50, 7'd0, 7'd0}, 1'b0, '0, '0);
    for (int w = 0; w < 20 && obs4_q.size() < exp4_q.size(); w++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (obs4_q.size() != exp4_q.size()) begin
      fails++; $display("FAIL wide_count: got %0d read events, expected %0d", obs4_q.size(), exp4_q.size());
    end
    while (exp4_q.size() > 0 && obs4_q.size() > 0) begin
      e = exp4_q.pop_front(); o = obs4_q.pop_front(); checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL wide_data: got cyc=%0d port=%0d data=%h, expected cyc=%0d port=%0d data=%h",
                 o.cyc, o.port, o.data, e.cyc, e.port, e.data);
      end
    end
    exp4_q.delete(); obs4_q.delete();
  endtask

  task automatic test_reset_mid_clear();
    int k, z1, z4, c;
    ev_t e, o;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_rdy !== 1'b0 || init_done !== 1'b0) begin
      fails++; $display("FAIL midclr_reset_flags: got rdy=%b done=%b, expected 0 0", wr_rdy, init_done);
    end
    rst_n = 1'b1;
    k = cyc; z1 = 0; z4 = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!wr_rdy) z1++;
      if (!wr_rdy4) z4++;
      if (wr_rdy && wr_rdy4) break;
    end
    checks++;
    if (z1 != 64) begin fails++; $display("FAIL midclr_duration: got %0d cycles with wr_rdy=0, expected 64 (from cyc %0d)", z1, k); end
    checks++;
    if (z4 != 128) begin fails++; $display("FAIL midclr_duration_dut4: got %0d cycles with wr_rdy=0, expected 128", z4); end
    for (int i = 0; i < 64; i++) model[i] = '0;
    c = cyc; expect1(c + 2, 0, model[5]); expect1(c + 2, 1, model[9]);
    drive(2'b11, 6'd5, 6'd9, 1'b0, 6'd0, '0);
    c = cyc; expect4(c + 1, 0, '1); expect4(c + 1, 1, '1);
    drive4(4'b0011, {7'd0, 7'd0, 7'd127, 7'd0}, 1'b0, '0, '0);
    for (int w = 0; w < 20 && (obs_q.size() < exp_q.size() || obs4_q.size() < exp4_q.size()); w++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (obs_q.size() != exp_q.size() || obs4_q.size() != exp4_q.size()) begin
      fails++;
      $display("FAIL midclr_rd_count: got %0d/%0d read events, expected %0d/%0d",
               obs_q.size(), obs4_q.size(), exp_q.size(), exp4_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL midclr_rd_data: got cyc=%0d port=%0d data=%h, expected cyc=%0d port=%0d data=%h",
                 o.cyc, o.port, o.data, e.cyc, e.port, e.data);
      end
    end
    while (exp4_q.size() > 0 && obs4_q.size() > 0) begin
      e = exp4_q.pop_front(); o = obs4_q.pop_front(); checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL midclr_rd_data_dut4: got cyc=%0d port=%0d data=%h, expected cyc=%0d port=%0d data=%h",
                 o.cyc, o.port, o.data, e.cyc, e.port, e.data);
      end
    end
    exp_q.delete(); obs_q.delete(); exp4_q.delete(); obs4_q.delete();
  endtask

  initial begin
    $display("[TB] starting ra_sdr_nr1w bench (bypass=%0d)", BYP);
    test_reset();
    test_clear();
    test_write_read();
    test_same_edge();
    test_back_to_back();
    test_wide_ports();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ra_sdr_nr1w.md
# ra_sdr_nr1w

Parametrised SDR register-array wrapper: DEPTH x WIDTH storage, NRD read ports and one write port, built from 24-bit slices. It is the general-purpose successor to the fixed 64x72 2r1w array wrapper. It adds four things over that wrapper: configurable geometry, per-port read-valid, a hardware clear-on-reset sequencer with a write-ready handshake, and optional write-to-read forwarding. It sits between core pipeline logic and the toysram slices, and is used for register files and small tables.

## Interface
- `DEPTH`, default 64: entries; power of two, 16..256.
- `WIDTH`, default 72: bits per entry; multiple of 24.
- `NRD`, default 2: read ports, 1..4.
- `LATCHRD`, default 1: 1 = registered read data, 0 = unlatched.
- `INIT_VAL`, default 0: replicated per-bit value written during clear.
- `clk`  in  1  clock; all state is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rd_enb`  in  NRD  per-port read enable.
- `rd_adr`  in  NRD*log2(DEPTH)  port p occupies slice [p*AW +: AW].
- `rd_dat`  out  NRD*WIDTH  port p occupies slice [p*WIDTH +: WIDTH].
- `rd_val`  out  NRD  read data valid, aligned with `rd_dat`.
- `wr_enb`  in  1  write request.
- `wr_adr`  in  log2(DEPTH)  write address.
- `wr_dat`  in  WIDTH  write data.
- `wr_rdy`  out  1  write accepted when high; low during clear.
- `init_done`  out  1  clear sequence complete.

## Operation
- Input stage: `rd_enb`, `rd_adr`, `wr_enb`, `wr_adr` and `wr_dat` are registered on every edge. The async reset clears the enables and addresses to 0.
- Write: a request sampled at edge N with `wr_rdy`=1 updates storage at edge N+1. A request sampled while `wr_rdy`=0 is dropped; there is no retry.
- Read: the address sampled at edge N reads the array during cycle N..N+1.
- `rd_val[p]` is the registered `rd_enb[p]`, delayed to match `rd_dat`.
- `rd_dat[p]` is don't-care when `rd_val[p]`=0. It holds its last value when LATCHRD=1.
- Same-address read and write sampled at the same edge: the read returns the old contents (read-before-write), unless forwarding is enabled.
- Multiple read ports hitting the same address are independent and all return the same data.
- Clear sequencer FSM, states RST → CLR → RDY:
  - RST: held while `reset` is low. `wr_rdy`=0, `init_done`=0, counter=0.
  - CLR: entered on the first edge after reset deasserts. Writes INIT_VAL to address = counter, then increments the counter, one entry per cycle. Leaves CLR when the counter reaches DEPTH-1.
  - RDY: `wr_rdy`=1, `init_done`=1. Stays in RDY until reset.
- Read enables during CLR are suppressed: `rd_val`=0.
- Reset asserted mid-CLR returns the FSM to RST immediately. On release the clear restarts from address 0.
- Reset values: `rd_val`=0, `wr_rdy`=0, `init_done`=0. `rd_dat`=0 when LATCHRD=1; unlatched `rd_dat` is undefined until CLR has completed.

## Timing
- Read latency, enable sampled → data: 2 edges (visible after edge N+1) for LATCHRD=1; 1 edge (combinational in cycle N..N+1) for LATCHRD=0.
- Write: sampled at edge N, committed at edge N+1. A read sampled at edge N+1 sees the new data.
- Clear duration: DEPTH cycles after reset release. `init_done` rises at edge DEPTH+1 after release.
- `wr_rdy` is registered and changes only on state transitions.

## Configuration
- `RA_BYPASS_EN` defined: a read whose sampled address equals the sampled write address, at the same edge with the write accepted, returns the new `wr_dat`. This is a per-port compare-and-mux ahead of the read latch. Latency is unchanged.
- `RA_BYPASS_EN` undefined: read-before-write as stated in Operation. No compare logic is generated.

## Structure
- Shared package `ra_pkg`: the `clog2` function, the `RA_SLICE_W` = 24 constant, the FSM state encoding (RST/CLR/RDY) and a parameter-legality check function.
- Sub-module `ra_sdr_slice`: DEPTH x 24 storage with NRD read ports and one write port, instantiated WIDTH/24 times.
- Top level holds the input stage, the clear FSM, the write mux (sequencer vs user), the bypass logic and the read latch.

## Test plan
- Reset release, DEPTH=64 → `wr_rdy`=0 for 64 cycles, then 1. Reads of addresses 0, 31 and 63 all return 0 with `rd_val`=1 after 2 edges.
- Write 0xA5..A5 to address 5; read address 5 on port 1 one cycle later → 0xA5..A5, `rd_val[1]`=1, latency 2 (LATCHRD=1) or 1 (LATCHRD=0).
- Same edge: write 0x1234 to address 9, read address 9 (old value 0) → returns 0 without `RA_BYPASS_EN`, 0x1234 with it.
- Write attempted at cycle 10 of CLR → dropped. After `init_done`, that address reads INIT_VAL.
- Reset pulsed low at CLR count 20 → FSM returns to RST and `wr_rdy`=0. After release the clear runs a full DEPTH cycles again.
- NRD=4, WIDTH=48, DEPTH=128: all four ports read distinct addresses 0, 1, 126, 127 after writes of their index values → each port returns its own index.
